// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port data RAM between the CPU MEM stage and a
// loader port. Round-robin arbitration with one access per cycle. A loader lock
// gives the loader burst priority, but after LOCK_MAX consecutive locked loader
// grants a waiting CPU is let through for one cycle. Read data from the RAM
// arrives one cycle after the access and is routed to the requester that issued it.
module ram_arbiter #(
   parameter int RAM_ADDRESS_BITWIDTH = 16,
   parameter int DATA_WIDTH           = 32,
   parameter int LOCK_MAX             = 16
) (
   input  logic                            clk,
   input  logic                            reset_n,
   // CPU MEM-stage port
   input  logic                            cpu_req,
   input  logic                            cpu_wren,
   input  logic [RAM_ADDRESS_BITWIDTH-1:0] cpu_address,
   input  logic [DATA_WIDTH-1:0]           cpu_write_data,
   output logic                            cpu_ack,
   output logic                            cpu_read_valid,
   output logic [DATA_WIDTH-1:0]           cpu_read_data,
   // loader port
   input  logic                            ldr_req,
   input  logic                            ldr_wren,
   input  logic [RAM_ADDRESS_BITWIDTH-1:0] ldr_address,
   input  logic [DATA_WIDTH-1:0]           ldr_write_data,
   input  logic                            ldr_lock,
   output logic                            ldr_ack,
   output logic                            ldr_read_valid,
   output logic [DATA_WIDTH-1:0]           ldr_read_data,
   // RAM side
   output logic [RAM_ADDRESS_BITWIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0]           ram_write_data,
   output logic                            ram_wren,
   input  logic [DATA_WIDTH-1:0]           ram_data
);

   localparam int CW = $clog2(LOCK_MAX + 1);

   typedef enum logic {ST_OPEN, ST_LOCKED} state_t;
   typedef enum logic {GR_CPU, GR_LDR} requester_t;

   state_t          r_state;
   requester_t      r_last_grant;
   logic [CW-1:0]   r_lock_count;
   logic            r_cpu_read_valid;
   logic            r_ldr_read_valid;

   logic            w_lock_full;
   logic            w_grant_cpu;
   logic            w_grant_ldr;

   assign w_lock_full = (r_lock_count == CW'(LOCK_MAX));

   // Pick at most one requester for this cycle.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      w_grant_cpu = 1'b0;
      w_grant_ldr = 1'b0;
      if (r_state == ST_LOCKED && cpu_req && w_lock_full) begin
         // fairness slot: CPU has waited out a full locked burst
         w_grant_cpu = 1'b1;
      end else if (r_state == ST_LOCKED && ldr_req && ldr_lock) begin
         w_grant_ldr = 1'b1;
      end else if (cpu_req && ldr_req) begin
         // round-robin: the one that did not win last time
         if (r_last_grant == GR_LDR) w_grant_cpu = 1'b1;
         else                        w_grant_ldr = 1'b1;
      end else begin
         w_grant_cpu = cpu_req;
         w_grant_ldr = ldr_req;
      end
   end

   // Acks are suppressed while reset is held so nothing issues during reset.
   assign cpu_ack = w_grant_cpu & reset_n;
   assign ldr_ack = w_grant_ldr & reset_n;

   // Granted requester's fields drive the RAM; idle cycles drive zeros.
   always_comb begin
      ram_wren       = 1'b0;
      ram_address    = '0;
      ram_write_data = '0;
      if (cpu_ack) begin
         ram_wren       = cpu_wren;
         ram_address    = cpu_address;
         ram_write_data = cpu_write_data;
      end else if (ldr_ack) begin
         ram_wren       = ldr_wren;
         ram_address    = ldr_address;
         ram_write_data = ldr_write_data;
      end
   end

   // Arbitration FSM: lock state, burst length counter and round-robin pointer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_OPEN;
         r_last_grant <= GR_LDR;
         r_lock_count <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         if (cpu_ack)      r_last_grant <= GR_CPU;
         else if (ldr_ack) r_last_grant <= GR_LDR;

         case (r_state)
            ST_OPEN: begin
               if (ldr_ack && ldr_lock) begin
                  r_state      <= ST_LOCKED;
                  r_lock_count <= CW'(1);
               end
            end
            ST_LOCKED: begin
               if (!ldr_lock) begin
                  r_state      <= ST_OPEN;
                  r_lock_count <= '0;
               end else if (cpu_ack && w_lock_full) begin
                  r_lock_count <= '0;
               end else if (ldr_ack && cpu_req && !w_lock_full) begin
                  // burst length only matters while the CPU is waiting
                  r_lock_count <= r_lock_count + CW'(1);
               end
            end
            default: begin
               r_state      <= ST_OPEN;
               r_lock_count <= '0;
            end
         endcase
      end
   end

   // Remember which requester issued a read so the RAM's next-cycle data goes back to it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cpu_read_valid <= 1'b0;
         r_ldr_read_valid <= 1'b0;
      end else begin
         r_cpu_read_valid <= cpu_ack & ~cpu_wren;
         r_ldr_read_valid <= ldr_ack & ~ldr_wren;
      end
   end

   assign cpu_read_valid = r_cpu_read_valid;
   assign ldr_read_valid = r_ldr_read_valid;
   assign cpu_read_data  = r_cpu_read_valid ? ram_data : '0;
   assign ldr_read_data  = r_ldr_read_valid ? ram_data : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: reset checks, a table of directed vectors
// (single access, OPEN contention, lock fairness, lock release), a randomized
// run against a behavioural arbitration model, and asynchronous reset mid-read.
module tb_ram_arbiter;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int LM = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          cpu_req, cpu_wren, cpu_ack, cpu_read_valid;
   logic [AW-1:0] cpu_address;
   logic [DW-1:0] cpu_write_data, cpu_read_data;
   logic          ldr_req, ldr_wren, ldr_lock, ldr_ack, ldr_read_valid;
   logic [AW-1:0] ldr_address;
   logic [DW-1:0] ldr_write_data, ldr_read_data;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_write_data, ram_data;
   logic          ram_wren;

   ram_arbiter #(.RAM_ADDRESS_BITWIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LM)) dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_address(cpu_address),
      .cpu_write_data(cpu_write_data), .cpu_ack(cpu_ack),
      .cpu_read_valid(cpu_read_valid), .cpu_read_data(cpu_read_data),
      .ldr_req(ldr_req), .ldr_wren(ldr_wren), .ldr_address(ldr_address),
      .ldr_write_data(ldr_write_data), .ldr_lock(ldr_lock), .ldr_ack(ldr_ack),
      .ldr_read_valid(ldr_read_valid), .ldr_read_data(ldr_read_data),
      .ram_address(ram_address), .ram_write_data(ram_write_data),
      .ram_wren(ram_wren), .ram_data(ram_data)
   );

   always #5 clk = ~clk;

   // Single-port RAM with one-cycle read latency (low 8 address bits used).
   logic [DW-1:0] ram_mem [0:255];
   always @(posedge clk) begin
      if (ram_wren) ram_mem[ram_address[7:0]] <= ram_write_data;
      ram_data <= ram_mem[ram_address[7:0]];
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: who is "owed" the next slot, plus expected memory image.
   bit            m_locked;     // loader holds an exclusive burst
   int            m_streak;     // locked loader grants while CPU waits
   bit            m_last_cpu;   // previous grant went to the CPU
   logic [DW-1:0] m_mem [0:255];

   task automatic model_reset();
      m_locked   = 1'b0;
      m_streak   = 0;
      m_last_cpu = 1'b0;
   endtask

   // One clock cycle: drive at posedge+1, check combinational outputs mid-cycle,
   // check read return at next posedge+1.
   task automatic step(input bit cr, input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input bit lr, input bit lw, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                       input bit lk, output bit gc, output bit gl);
      bit            cpu_due, ldr_pri, pc, pl;
      logic [DW-1:0] pdc, pdl;
      logic          e_wren;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd;
      cpu_req = cr; cpu_wren = cw; cpu_address = ca; cpu_write_data = cd;
      ldr_req = lr; ldr_wren = lw; ldr_address = la; ldr_write_data = ld; ldr_lock = lk;
      #4;
      cpu_due = m_locked && cr && (m_streak == LM);
      ldr_pri = m_locked && lr && lk;
      gc = 1'b0; gl = 1'b0;
      if (cpu_due)       gc = 1'b1;
      else if (ldr_pri)  gl = 1'b1;
      else if (cr && lr) begin gc = !m_last_cpu; gl = m_last_cpu; end
      else begin gc = cr; gl = lr; end
      e_wren = gc ? cw : (gl ? lw : 1'b0);
      e_addr = gc ? ca : (gl ? la : '0);
      e_wd   = gc ? cd : (gl ? ld : '0);
      check("cpu_ack", cpu_ack, gc);
      check("ldr_ack", ldr_ack, gl);
      check("ram_wren", ram_wren, e_wren);
      check("ram_address", ram_address, e_addr);
      check("ram_write_data", ram_write_data, e_wd);
      pc  = gc && !cw;
      pl  = gl && !lw;
      pdc = m_mem[ca[7:0]];
      pdl = m_mem[la[7:0]];
      if (gc && cw) m_mem[ca[7:0]] = cd;
      if (gl && lw) m_mem[la[7:0]] = ld;
      if (gc || gl) m_last_cpu = gc;
      if (!m_locked) begin
         if (gl && lk) begin m_locked = 1'b1; m_streak = 1; end
      end else if (!lk) begin
         m_locked = 1'b0; m_streak = 0;
      end else if (gc && cpu_due) begin
         m_streak = 0;
      end else if (gl && cr && m_streak < LM) begin
         m_streak++;
      end
      @(posedge clk); #1;
      check("cpu_read_valid", cpu_read_valid, pc);
      check("cpu_read_data", cpu_read_data, pc ? pdc : '0);
      check("ldr_read_valid", ldr_read_valid, pl);
      check("ldr_read_data", ldr_read_data, pl ? pdl : '0);
   endtask

   typedef struct {
      bit            cr, cw;
      logic [AW-1:0] ca;
      logic [DW-1:0] cd;
      bit            lr, lw, lk;
      bit            e_ca, e_la;
   } vec_t;

   vec_t vt[$];

   task automatic add(input bit cr, input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                      input bit lr, input bit lw, input bit lk, input bit e_ca, input bit e_la);
      vec_t v;
      v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
      v.lr = lr; v.lw = lw; v.lk = lk; v.e_ca = e_ca; v.e_la = e_la;
      vt.push_back(v);
   endtask

   initial begin
      bit gc, gl, lk_r;
      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = '0;
         m_mem[i]   = '0;
      end
      model_reset();

      // Reset held with both requesting: nothing may issue.
      reset_n = 1'b0;
      cpu_req = 1'b1; cpu_wren = 1'b1; cpu_address = 16'h0001; cpu_write_data = 32'h1111_1111;
      ldr_req = 1'b1; ldr_wren = 1'b1; ldr_address = 16'h0002; ldr_write_data = 32'h2222_2222;
      ldr_lock = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check("rst_cpu_ack", cpu_ack, 1'b0);
      check("rst_ldr_ack", ldr_ack, 1'b0);
      check("rst_ram_wren", ram_wren, 1'b0);
      check("rst_cpu_rv", cpu_read_valid, 1'b0);
      check("rst_ldr_rv", ldr_read_valid, 1'b0);
      check("rst_cpu_rd", cpu_read_data, 32'h0);
      check("rst_ldr_rd", ldr_read_data, 32'h0);
      reset_n = 1'b1;

      // Directed table: cr cw ca cd | lr lw lk | expected cpu_ack ldr_ack
      add(1, 1, 16'h0010, 32'hDEADBEEF, 1, 1, 0, 1, 0); // first tie -> CPU
      add(1, 0, 16'h0010, 32'h0,        0, 0, 0, 1, 0); // read back
      add(1, 1, 16'h0011, 32'h1,        1, 1, 0, 0, 1); // alternation
      add(1, 1, 16'h0012, 32'h2,        1, 1, 0, 1, 0);
      add(1, 1, 16'h0012, 32'h3,        1, 1, 0, 0, 1);
      add(1, 1, 16'h0012, 32'h4,        1, 1, 0, 1, 0);
      add(0, 0, 16'h0000, 32'h0,        0, 0, 0, 0, 0); // idle
      for (int i = 0; i < 2; i++) begin                 // lock fairness: 4 LDR, 1 CPU
         for (int k = 0; k < LM; k++) add(1, 0, 16'h0013, 32'h0, 1, 1, 1, 0, 1);
         add(1, 0, 16'h0013, 32'h0, 1, 1, 1, 1, 0);
      end
      add(1, 0, 16'h0013, 32'h0, 1, 1, 1, 0, 1);        // lock release after 2
      add(1, 0, 16'h0013, 32'h0, 1, 1, 1, 0, 1);
      add(1, 0, 16'h0013, 32'h0, 1, 1, 0, 1, 0);        // lock dropped -> CPU
      add(1, 0, 16'h0013, 32'h0, 1, 1, 0, 0, 1);        // back in OPEN
      add(0, 0, 16'h0000, 32'h0, 0, 0, 0, 0, 0);
      add(0, 0, 16'h0000, 32'h0, 1, 1, 1, 0, 1);        // enter lock
      add(1, 0, 16'h0010, 32'h0, 0, 0, 1, 1, 0);        // ldr idle -> CPU served
      add(1, 0, 16'h0010, 32'h0, 1, 1, 1, 0, 1);
      add(0, 0, 16'h0000, 32'h0, 0, 0, 0, 0, 0);

      for (int i = 0; i < vt.size(); i++) begin
         step(vt[i].cr, vt[i].cw, vt[i].ca, vt[i].cd,
              vt[i].lr, vt[i].lw, 16'h0080 + 16'(i), 32'hA000_0000 + 32'(i), vt[i].lk, gc, gl);
         check($sformatf("vec%0d_cpu_ack", i), cpu_ack === 1'bx ? 1'bx : gc, vt[i].e_ca);
         check($sformatf("vec%0d_ldr_ack", i), gl, vt[i].e_la);
         if (i == 1) begin
            check("single_rd_valid", cpu_read_valid, 1'b1);
            check("single_rd_data", cpu_read_data, 32'hDEADBEEF);
            check("single_rd_ldr_rv", ldr_read_valid, 1'b0);
         end
      end

      // Randomized traffic with a sticky lock so bursts form.
      lk_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) lk_r = !lk_r;
         step($urandom_range(0, 3) != 0, 1'($urandom), 16'($urandom_range(0, 255)), $urandom,
              $urandom_range(0, 3) != 0, 1'($urandom), 16'($urandom_range(0, 255)), $urandom,
              lk_r, gc, gl);
      end
      step(0, 0, 16'h0, 32'h0, 0, 0, 16'h0, 32'h0, 0, gc, gl);

      // Async reset right after a loader read ack.
      step(0, 0, 16'h0, 32'h0, 1, 0, 16'h0010, 32'h0, 0, gc, gl);
      check("pre_rst_ldr_rv", ldr_read_valid, 1'b1);
      cpu_req = 1'b1; cpu_wren = 1'b1; ldr_req = 1'b1; ldr_wren = 1'b1;
      #1 reset_n = 1'b0;
      #1;
      check("midrst_ldr_rv", ldr_read_valid, 1'b0);
      check("midrst_ldr_rd", ldr_read_data, 32'h0);
      check("midrst_cpu_ack", cpu_ack, 1'b0);
      check("midrst_ldr_ack", ldr_ack, 1'b0);
      check("midrst_ram_wren", ram_wren, 1'b0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      model_reset();
      #2;
      check("postrst_ldr_rv", ldr_read_valid, 1'b0);
      check("postrst_cpu_rv", cpu_read_valid, 1'b0);
      step(1, 0, 16'h0010, 32'h0, 1, 0, 16'h0011, 32'h0, 0, gc, gl);
      check("postrst_first_cpu", gc, 1'b1);
      step(0, 0, 16'h0, 32'h0, 0, 0, 16'h0, 32'h0, 0, gc, gl);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port data RAM between the CPU MEM stage and a program/data loader port, so memory can be filled or inspected while the core runs. Round-robin arbitration, one access per cycle, with a loader lock for burst transfers bounded by a CPU-fairness limit. Sits between the MEM-stage RAM signals and the RAM instance. Routes the 1-cycle-latency read data back to whichever requester issued the access.

## Interface
- RAM_ADDRESS_BITWIDTH, 16: address width of the RAM and of both requester ports.
- DATA_WIDTH, 32: word width.
- LOCK_MAX, 16: maximum number of consecutive locked loader grants while the CPU is requesting (≥1).
- clk  in  1  system clock, all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request, held until cpu_ack.
- cpu_wren  in  1  1 = write, 0 = read.
- cpu_address  in  RAM_ADDRESS_BITWIDTH  CPU word address.
- cpu_write_data  in  DATA_WIDTH  CPU write data.
- cpu_ack  out  1  access issued this cycle (combinational).
- cpu_read_valid  out  1  cpu_read_data valid (registered).
- cpu_read_data  out  DATA_WIDTH  read result.
- ldr_req, ldr_wren, ldr_address, ldr_write_data  in  1/1/RAM_ADDRESS_BITWIDTH/DATA_WIDTH  loader request fields, same meaning as CPU.
- ldr_lock  in  1  loader requests exclusive burst.
- ldr_ack, ldr_read_valid, ldr_read_data  out  1/1/DATA_WIDTH  loader responses.
- ram_address  out  RAM_ADDRESS_BITWIDTH  to RAM.
- ram_write_data  out  DATA_WIDTH  to RAM.
- ram_wren  out  1  RAM write enable.
- ram_data  in  DATA_WIDTH  RAM read data, valid the cycle after address presentation.

## Operation
- Each cycle at most one requester is granted. Its address/write data/wren drive the RAM combinationally, and its ack is high that cycle. The requester drops or changes its request on the next edge.
- No request: ram_wren=0, ram_address/ram_write_data=0, both acks 0.
- FSM states: OPEN and LOCKED.
- OPEN:
  - Only one requester active: grant it.
  - Both active: grant the requester not in last_grant (round-robin). last_grant updates on every grant.
  - Loader granted with ldr_lock=1: go to LOCKED and set lock_count=1.
- LOCKED:
  - Loader has priority while ldr_req=1 and ldr_lock=1. Each loader grant increments lock_count, saturating at LOCK_MAX.
  - If cpu_req=1 and lock_count==LOCK_MAX: grant the CPU for one cycle, clear lock_count to 0, stay LOCKED.
  - CPU is also granted in any cycle with ldr_req=0.
  - ldr_lock=0 (sampled on the edge): return to OPEN, clear lock_count.
  - lock_count counts only while cpu_req=1. When cpu_req=0 it holds.
- Read return:
  - A read grant in cycle N sets that requester's read_valid for exactly cycle N+1.
  - read_data = ram_data, gated to 0 when read_valid=0.
  - Write grants produce no read_valid.
- No forwarding or ordering between ports. Same-address read-after-write takes RAM semantics.

## Timing
- Reset (reset_n=0, asynchronous):
  - state=OPEN, last_grant=LOADER (CPU wins first tie), lock_count=0.
  - Both read_valid=0 and both read_data=0.
  - Acks and ram_wren forced 0 while reset_n is low.
- Ack latency: 0 cycles (same cycle as the granted request). Read data latency: 1 cycle after ack.
- Back-to-back grants to the same requester are allowed every cycle, e.g. a single requester streaming.
- Reset mid-access: any pending read_valid is dropped. No write issues in the reset cycle.
- CPU worst-case wait under lock: LOCK_MAX cycles. Under OPEN contention: 1 cycle.

## Test plan
- Reset: hold reset_n=0 with cpu_req=ldr_req=1 → acks=0, ram_wren=0. Release → the first grant goes to CPU.
- Single CPU write: addr 0x0010, data 0xDEADBEEF → cpu_ack and ram_wren high that cycle. A CPU read of 0x0010 then gives cpu_read_valid=1 and cpu_read_data=0xDEADBEEF one cycle after its ack; ldr_read_valid stays 0.
- Contention in OPEN: both request continuously, loader unlocked → grants alternate CPU, LDR, CPU, LDR…
- Lock fairness: LOCK_MAX=4, loader locked streaming writes, cpu_req held → 4 loader acks, 1 CPU ack, 4 loader acks, repeat.
- Lock release: drop ldr_lock after 2 locked grants with cpu_req=1 → next cycle is OPEN. The CPU is granted next because last_grant=LOADER.
- Async reset asserted the cycle after a loader read ack → ldr_read_valid goes low immediately and stays 0 after release.
